// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: request sequencer for a 4-digit 7-segment decoder.
// It accepts a number, dash or error request over valid/ready. Numbers are
// converted to BCD with a serial double-dabble, one shift per clock. The four
// digit codes are held steady until the next request completes.
module bcd_display_ctrl #(
  parameter int unsigned VALUE_W   = 14,
  parameter int unsigned MAX_VALUE = 9999,
  parameter int unsigned LZ_BLANK  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic [1:0]         in_mode,
  output logic [3:0]         digit0,
  output logic [3:0]         digit1,
  output logic [3:0]         digit2,
  output logic [3:0]         digit3,
  output logic               disp_valid,
  output logic               upd
);

  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  localparam logic [1:0] MODE_NUM  = 2'b00;
  localparam logic [1:0] MODE_DASH = 2'b01;

  localparam logic [BCD_W-1:0] PAT_DASH  = 16'hDDDD;  // "----"
  localparam logic [BCD_W-1:0] PAT_ERR   = 16'hABBC;  // "Erro"
  localparam logic [3:0]       CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [VALUE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [CNT_W-1:0]   cnt;
  logic               is_num;

  logic               accept_c;
  logic               num_ok_c;
  logic               conv_last_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W-1:0]   load_digits_c;

  // Add 3 to every BCD nibble of 5 or more, ahead of the shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Turn leading zeros of digit3..digit1 into blanks; digit0 always stays.
  function automatic logic [BCD_W-1:0] lz_apply(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    if (r[15:12] == 4'd0) begin
      r[15:12] = CODE_BLANK;
      if (r[11:8] == 4'd0) begin
        r[11:8] = CODE_BLANK;
        if (r[7:4] == 4'd0) begin
          r[7:4] = CODE_BLANK;
        end
      end
    end
    return r;
  endfunction

  // Ready only while idle and out of reset.
  assign in_ready = (state == IDLE) && !reset;

  // Request decode and datapath helpers.
  always_comb begin
    accept_c      = in_valid && in_ready;
    num_ok_c      = (in_mode == MODE_NUM) && (32'(in_value) <= 32'(MAX_VALUE));
    conv_last_c   = (cnt == CNT_W'(VALUE_W - 1));
    bcd_adj_c     = dabble_adj(bcd_sr);
    load_digits_c = bcd_sr;
    if ((LZ_BLANK != 0) && is_num) begin
      load_digits_c = lz_apply(bcd_sr);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_next = num_ok_c ? CONV : LOAD;
        end
      end
      CONV: begin
        if (conv_last_c) begin
          state_next = LOAD;
        end
      end
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift registers: capture on accept, one double-dabble step per CONV cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      is_num <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            cnt <= '0;
            if (num_ok_c) begin
              bin_sr <= in_value;
              bcd_sr <= '0;
              is_num <= 1'b1;
            end else begin
              // Fixed patterns ride through LOAD in the BCD register.
              bin_sr <= '0;
              bcd_sr <= (in_mode == MODE_DASH) ? PAT_DASH : PAT_ERR;
              is_num <= 1'b0;
            end
          end
        end
        CONV: begin
          bcd_sr <= {bcd_adj_c[BCD_W-2:0], bin_sr[VALUE_W-1]};
          bin_sr <= {bin_sr[VALUE_W-2:0], 1'b0};
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Display registers: only LOAD changes the digits, so nothing partial shows.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit3     <= 4'hD;
      digit2     <= 4'hD;
      digit1     <= 4'hD;
      digit0     <= 4'hD;
      disp_valid <= 1'b0;
      upd        <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (state == LOAD) begin
        digit3     <= load_digits_c[15:12];
        digit2     <= load_digits_c[11:8];
        digit1     <= load_digits_c[7:4];
        digit0     <= load_digits_c[3:0];
        disp_valid <= 1'b1;
        upd        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: directed scenarios plus random traffic,
// checked each cycle against a latency/arithmetic reference model.
module tb_bcd_display_ctrl;

  localparam int unsigned VALUE_W = 14;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic [VALUE_W-1:0] in_value = '0;
  logic [1:0]         in_mode = 2'b00;

  logic       in_ready, disp_valid, upd;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       lz_ready, lz_disp_valid, lz_upd;
  logic [3:0] lz_d0, lz_d1, lz_d2, lz_d3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_display_ctrl #(.VALUE_W(VALUE_W), .MAX_VALUE(9999), .LZ_BLANK(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_mode(in_mode),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .disp_valid(disp_valid), .upd(upd)
  );

  bcd_display_ctrl #(.VALUE_W(VALUE_W), .MAX_VALUE(9999), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(lz_ready),
    .in_value(in_value), .in_mode(in_mode),
    .digit0(lz_d0), .digit1(lz_d1), .digit2(lz_d2), .digit3(lz_d3),
    .disp_valid(lz_disp_valid), .upd(lz_upd)
  );

  wire [15:0] dig    = {digit3, digit2, digit1, digit0};
  wire [15:0] dig_lz = {lz_d3, lz_d2, lz_d1, lz_d0};

  // What the display must read for a request, from plain decimal arithmetic.
  function automatic logic [15:0] exp_digits(input logic [1:0] mode, input int v, input bit lz);
    int d[4];
    if (mode == 2'b01) return 16'hDDDD;
    if (mode != 2'b00 || v > 9999) return 16'hABBC;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    if (lz) begin
      if (v < 1000) d[3] = 15;
      if (v < 100)  d[2] = 15;
      if (v < 10)   d[1] = 15;
    end
    return {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
  endfunction

  // Reference model: a request completes a fixed number of clocks after accept.
  bit         m_on = 1'b0;
  int         rem = 0;
  logic [15:0] e_dig, e_dig_lz, p_dig, p_dig_lz;
  logic        e_dv, e_upd;

  always @(posedge clk) begin
    if (reset) begin
      m_on     <= 1'b1;
      rem      <= 0;
      e_dig    <= 16'hDDDD;
      e_dig_lz <= 16'hDDDD;
      e_dv     <= 1'b0;
      e_upd    <= 1'b0;
    end else if (m_on) begin
      e_upd <= 1'b0;
      if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          e_dig    <= p_dig;
          e_dig_lz <= p_dig_lz;
          e_dv     <= 1'b1;
          e_upd    <= 1'b1;
        end
      end else if (in_valid) begin
        p_dig    <= exp_digits(in_mode, int'(in_value), 1'b0);
        p_dig_lz <= exp_digits(in_mode, int'(in_value), 1'b1);
        // Latency counts the accept cycle as 1 and the upd cycle as the last.
        rem      <= (in_mode == 2'b00 && int'(in_value) <= 9999) ? VALUE_W + 1 : 1;
      end
    end
  end

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_on) begin
      cmp("digits",        dig,                   e_dig);
      cmp("digits_lz",     dig_lz,                e_dig_lz);
      cmp("disp_valid",    16'(disp_valid),       16'(e_dv));
      cmp("disp_valid_lz", 16'(lz_disp_valid),    16'(e_dv));
      cmp("upd",           16'(upd),              16'(e_upd));
      cmp("upd_lz",        16'(lz_upd),           16'(e_upd));
      cmp("in_ready",      16'(in_ready),         16'(!reset && rem == 0));
      cmp("in_ready_lz",   16'(lz_ready),         16'(!reset && rem == 0));
    end
  end

  task automatic send(input logic [1:0] m, input int v, input bit hold);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_mode  = m;
    in_value = VALUE_W'(v);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready still %0b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_upd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < 100);
    if (!upd) begin
      checks++; errors++;
      $display("FAIL upd_timeout: upd still %0b after %0d cycles, expected 1", upd, n);
    end
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    cmp("lit_reset_digits", dig, 16'hDDDD);
    cmp("lit_reset_dv", 16'(disp_valid), 16'h0);
    cmp("lit_reset_ready", 16'(in_ready), 16'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Number conversion and the range boundary.
    send(2'b00, 1234, 1'b0); wait_upd();
    cmp("lit_1234", dig, 16'h1234);
    cmp("lit_1234_dv", 16'(disp_valid), 16'h1);
    send(2'b00, 9999, 1'b0);  wait_upd(); cmp("lit_9999", dig, 16'h9999);
    send(2'b00, 10000, 1'b0); wait_upd(); cmp("lit_10000", dig, 16'hABBC);
    send(2'b00, 16383, 1'b0); wait_upd(); cmp("lit_16383", dig, 16'hABBC);

    // Fixed patterns.
    send(2'b01, 55, 1'b0); wait_upd(); cmp("lit_dash", dig, 16'hDDDD);
    send(2'b11, 0, 1'b0);  wait_upd(); cmp("lit_mode3", dig, 16'hABBC);

    // Leading-zero blanking.
    send(2'b00, 7, 1'b0);    wait_upd(); cmp("lit_lz_7", dig_lz, 16'hFFF7); cmp("lit_7", dig, 16'h0007);
    send(2'b00, 0, 1'b0);    wait_upd(); cmp("lit_lz_0", dig_lz, 16'hFFF0);
    send(2'b00, 1005, 1'b0); wait_upd(); cmp("lit_lz_1005", dig_lz, 16'h1005);

    // in_valid held through a busy period.
    send(2'b00, 42, 1'b1);
    in_value = VALUE_W'(77);
    wait_upd(); cmp("lit_42", dig, 16'h0042);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_upd(); cmp("lit_77", dig, 16'h0077);

    // Reset in the middle of a conversion.
    send(2'b00, 1234, 1'b0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    cmp("lit_abort_digits", dig, 16'hDDDD);
    cmp("lit_abort_dv", 16'(disp_valid), 16'h0);
    send(2'b00, 5678, 1'b0); wait_upd(); cmp("lit_5678", dig, 16'h5678);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(0, 249) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_mode  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) in_mode = 2'b00;
      case ($urandom_range(0, 7))
        0: in_value = VALUE_W'(0);
        1: in_value = VALUE_W'(9999);
        2: in_value = VALUE_W'(10000);
        3: in_value = VALUE_W'($urandom_range(0, 9));
        default: in_value = VALUE_W'($urandom_range(0, 16383));
      endcase
    end
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
